lifo_burst_reader: RTL and testbench
====================================

LIFO_BURST_READER -- requirements
Module: lifo_burst_reader

Interface
REQ-001 Parameter DWIDTH, default 16: data word width; matches the upstream LIFO.
REQ-002 Parameter AWIDTH, default 8: LIFO address width; usedw is AWIDTH+1 bits.
REQ-003 Parameter BURST_LEN, default 4: words per full burst; range 1..2**AWIDTH.
REQ-004 clk  in  1: single clock; all state changes on rising edge.
REQ-005 arst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 flush  in  1: request a partial burst of whatever the LIFO holds (<= BURST_LEN).
REQ-007 lifo_q  in  DWIDTH: LIFO read data, valid the cycle after lifo_rdreq.
REQ-008 lifo_empty  in  1: LIFO empty flag.
REQ-009 lifo_usedw  in  AWIDTH+1: LIFO occupancy.
REQ-010 lifo_rdreq  out  1: LIFO pop strobe.
REQ-011 out_data  out  DWIDTH: downstream data.
REQ-012 out_valid  out  1: out_data valid.
REQ-013 out_last  out  1: qualifies the final word of a burst.
REQ-014 out_ready  in  1: downstream accept.
REQ-015 busy  out  1: high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, DRAIN, WAIT.
REQ-017 IDLE->DRAIN when lifo_usedw >= BURST_LEN; burst length latched = BURST_LEN.
REQ-018 Otherwise IDLE->DRAIN when flush=1 and lifo_empty=0; latched length = lifo_usedw, sampled that cycle.
REQ-019 flush=1 with lifo_empty=1 in IDLE: no action.
REQ-020 flush outside IDLE: ignored; not queued.
REQ-021 Remaining counter rem loads the latched length on entry to DRAIN and decrements by 1 per lifo_rdreq.
REQ-022 lifo_rdreq=1 only in DRAIN with rem>0, lifo_empty=0, and (buffer occupancy + reads in flight) < 2.
REQ-023 DRAIN->WAIT on the cycle issuing the lifo_rdreq that makes rem 0.
REQ-024 Read latency is exactly 1 cycle: lifo_q is captured into the output buffer the cycle after lifo_rdreq, with a last tag set iff that read made rem 0.
REQ-025 Output buffer: 2-entry FIFO; out_data/out_last come from its head; out_valid = buffer not empty.
REQ-026 Transfer occurs when out_valid && out_ready.
REQ-027 out_data and out_last hold stable while out_valid=1 and out_ready=0.
REQ-028 The buffer never overflows under any out_ready pattern.
REQ-029 Simultaneous capture and transfer in one cycle: occupancy unchanged; order preserved.
REQ-030 WAIT->IDLE on transfer of the word with out_last=1.
REQ-031 A new burst may start the cycle after returning to IDLE.
REQ-032 Throughput: with out_ready held high, one word per cycle after a 2-cycle start latency (trigger cycle, then first rdreq).
REQ-033 Words emit in LIFO pop order (most recent first); no reordering or duplication.

Reset
REQ-034 arst_n=0 immediately forces: state IDLE, rem 0, buffer empty, in-flight cleared, lifo_rdreq=0, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-035 Reset mid-burst discards buffered and in-flight words; lifo_q arriving after reset release is ignored.

Configuration
REQ-036 Macro LIFO_BURST_READER_STATS_EN, when defined: adds output burst_cnt [15:0], incremented on each out_last transfer, wrapping 0xFFFF->0, reset to 0.
REQ-037 Macro LIFO_BURST_READER_STATS_EN, when undefined: burst_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 BURST_LEN=4; LIFO pushed 10,11,12,13; out_ready=1 -> out_data 13,12,11,10 on consecutive cycles; out_last only on 10; busy falls after last.
REQ-039 LIFO holds 2 words (5,6); flush pulse -> out_data 6,5 with out_last on 5; rdreq count = 2.
REQ-040 Burst of 4 with out_ready low 5 cycles, then high -> at most 2 rdreq before ready rises; data held stable; all 4 words delivered in order.
REQ-041 Random out_ready (50%) over 100 bursts -> no loss, no duplication, exactly one out_last per burst.
REQ-042 arst_n low for 1 cycle after the 2nd word of a burst -> outputs zero immediately; after release, no stale word appears; next trigger starts a clean burst.
REQ-043 With LIFO_BURST_READER_STATS_EN defined: 3 completed bursts -> burst_cnt=3; flush with lifo_empty=1 -> burst_cnt unchanged and busy stays 0.

Source files
------------

// File: rtl/lifo_burst_reader.sv
// lifo_burst_reader: pulls bursts of words from an upstream LIFO (1-cycle read
// latency) and presents them through a 2-entry output buffer with
// valid/ready handshaking and a last-word marker.
// A full burst of BURST_LEN words starts whenever the LIFO holds that many;
// a flush pulse drains whatever smaller amount the LIFO holds.
// Optional feature: define LIFO_BURST_READER_STATS_EN to add the burst_cnt
// output, which counts completed bursts.
module lifo_burst_reader #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic [DWIDTH-1:0] lifo_q,
  input  logic              lifo_empty,
  input  logic [AWIDTH:0]   lifo_usedw,
  output logic              lifo_rdreq,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
`ifdef LIFO_BURST_READER_STATS_EN
  ,
  output logic [15:0]       burst_cnt
`endif
);

  localparam logic [AWIDTH:0] BURST_LEN_W = (AWIDTH+1)'(BURST_LEN);
  localparam logic [AWIDTH:0] REM_ONE     = (AWIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [AWIDTH:0]   rem_q;

  // One read can be in flight at a time per cycle; its last tag travels with it.
  logic              infl_q;
  logic              infl_last_q;

  // Two-entry output buffer.
  logic [DWIDTH-1:0] buf0_q;
  logic [DWIDTH-1:0] buf1_q;
  logic              last0_q;
  logic              last1_q;
  logic              wptr_q;
  logic              rptr_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;

  logic              xfer;
  logic              capture;
  logic              last_read;
  logic [1:0]        credit;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = rptr_q ? buf1_q : buf0_q;
  assign out_last  = out_valid && (rptr_q ? last1_q : last0_q);
  assign busy      = (state_q != S_IDLE);

  // Read issue: the slot freed by a transfer this cycle is reusable at once,
  // which is what allows one word per cycle with out_ready held high while
  // still guaranteeing that every issued read has a buffer slot on arrival.
  always_comb begin
    xfer       = out_valid && out_ready;
    capture    = infl_q;
    credit     = cnt_q + {1'b0, infl_q} - {1'b0, xfer};
    lifo_rdreq = (state_q == S_DRAIN) && (rem_q != '0) && !lifo_empty &&
                 (credit < 2'd2);
    last_read  = lifo_rdreq && (rem_q == REM_ONE);
    cnt_d      = cnt_q + {1'b0, capture} - {1'b0, xfer};
  end

  // Control FSM: trigger detection, burst length latch, remaining-word count.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lifo_usedw >= BURST_LEN_W) begin
            state_q <= S_DRAIN;
            rem_q   <= BURST_LEN_W;
          end else if (flush && !lifo_empty) begin
            state_q <= S_DRAIN;
            rem_q   <= lifo_usedw;
          end
        end
        S_DRAIN: begin
          if (lifo_rdreq) begin
            rem_q <= rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (xfer && out_last) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // In-flight tracking: lifo_q is valid exactly one cycle after a read.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= lifo_rdreq;
      infl_last_q <= last_read;
    end
  end

  // Output buffer: capture returning read data, release head on transfer.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      buf0_q  <= '0;
      buf1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      if (capture) begin
        if (wptr_q) begin
          buf1_q  <= lifo_q;
          last1_q <= infl_last_q;
        end else begin
          buf0_q  <= lifo_q;
          last0_q <= infl_last_q;
        end
        wptr_q <= ~wptr_q;
      end
      if (xfer) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

`ifdef LIFO_BURST_READER_STATS_EN
  // Completed-burst counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      burst_cnt <= 16'd0;
    end else if (xfer && out_last) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lifo_burst_reader.sv
// Testbench for lifo_burst_reader: a behavioural LIFO drives the DUT, and a
// reference model turns pushes/flushes into the expected word stream.
module tb_lifo_burst_reader;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          flush;
  logic [DW-1:0] lifo_q;
  logic          lifo_empty;
  logic [AW:0]   lifo_usedw;
  logic          lifo_rdreq;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
`ifdef LIFO_BURST_READER_STATS_EN
  logic [15:0]   burst_cnt;
`endif

  always #5 clk = ~clk;

  lifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .flush      (flush),
    .lifo_q     (lifo_q),
    .lifo_empty (lifo_empty),
    .lifo_usedw (lifo_usedw),
    .lifo_rdreq (lifo_rdreq),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef LIFO_BURST_READER_STATS_EN
    , .burst_cnt (burst_cnt)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Upstream LIFO seen by the DUT.
  logic [DW-1:0] mem [512];
  int            sp = 0;

  // Reference model: model stack and expected output stream.
  logic [DW-1:0] rstk  [$];
  logic [DW-1:0] exp_d [$];
  bit            exp_l [$];

  // Observed transfers for literal checks.
  logic [DW-1:0] log_d [$];
  bit            log_l [$];
  int            log_cyc [$];

  int   cyc_n = 0;
  int   rd_cnt = 0;
  int   first_rd_cyc = -1;
  int   issued = 0;
  int   delivered = 0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_last = 1'b0;
  int   model_bursts = 0;
  int   dut_lasts = 0;
  int   lasts_since_rst = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    cmp_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc_n);
    end
  endtask

  task automatic fail(input string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s (cycle %0d)", name, cyc_n);
  endtask

  // Whole bursts are taken from the top of the stack as long as enough words exist.
  function automatic void model_settle();
    while (rstk.size() >= BL) begin
      for (int i = 0; i < BL; i++) begin
        exp_d.push_back(rstk.pop_back());
        exp_l.push_back(i == BL - 1);
      end
      model_bursts++;
    end
  endfunction

  // A flush in idle empties whatever (fewer than BL) words remain.
  function automatic void model_flush();
    int n;
    n = rstk.size();
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(rstk.pop_back());
      exp_l.push_back(i == n - 1);
    end
    if (n > 0) model_bursts++;
  endfunction

  task automatic upd_lifo();
    lifo_usedw = (AW+1)'(sp);
    lifo_empty = (sp == 0);
  endtask

  task automatic push_one(input logic [DW-1:0] v);
    mem[9'(sp)] = v;
    sp++;
    rstk.push_back(v);
  endtask

  task automatic commit();
    model_settle();
    upd_lifo();
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_cyc.delete();
    rd_cnt = 0;
    first_rd_cyc = -1;
  endtask

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic cyc();
    bit rd;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data",  32'(out_data),  32'(prev_data));
      chk("hold_last",  32'(out_last),  32'(prev_last));
    end
    if (out_valid) begin
      if (exp_d.size() == 0) begin
        fail("unexpected_word");
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_d[0]));
        chk("out_last", 32'(out_last), 32'(exp_l[0]));
        if (out_ready) begin
          log_d.push_back(out_data);
          log_l.push_back(out_last);
          log_cyc.push_back(cyc_n);
          void'(exp_d.pop_front());
          void'(exp_l.pop_front());
          delivered++;
          if (out_last) begin
            dut_lasts++;
            lasts_since_rst++;
          end
        end
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    rd = lifo_rdreq;
    if (rd) begin
      if (sp == 0) fail("rdreq_on_empty");
      rd_cnt++;
      issued++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc_n;
    end
    chk("occupancy_le2", 32'(issued - delivered <= 2), 32'd1);
    @(posedge clk);
    #1;
    if (rd && sp > 0) begin
      sp--;
      lifo_q = mem[9'(sp)];
      upd_lifo();
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drain(input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cyc();
      if (exp_d.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) fail("drain_timeout");
  endtask

  task automatic chk_log(input string tag, input int n,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    chk({tag, "_count"}, 32'(log_d.size()), 32'(n));
    for (int i = 0; i < n && i < log_d.size(); i++) begin
      chk({tag, "_data"}, 32'(log_d[i]), 32'(w[i]));
      chk({tag, "_last"}, 32'(log_l[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    int start_b;
    int start_l;

    arst_n    = 1'b0;
    flush     = 1'b0;
    lifo_q    = '0;
    out_ready = 1'b0;
    upd_lifo();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_rdreq", 32'(lifo_rdreq), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);

    // Full burst, out_ready high
    clear_log();
    out_ready = 1'b1;
    c0 = cyc_n;
    push_one(16'd10); push_one(16'd11); push_one(16'd12); push_one(16'd13);
    commit();
    drain(1'b0);
    chk_log("full_burst", 4, 16'd13, 16'd12, 16'd11, 16'd10);
    chk("full_first_rd", 32'(first_rd_cyc), 32'(c0 + 1));
    if (log_cyc.size() == 4) begin
      chk("full_first_word", 32'(log_cyc[0]), 32'(c0 + 3));
      for (int i = 1; i < 4; i++) chk("full_consecutive", 32'(log_cyc[i]), 32'(log_cyc[0] + i));
      chk("full_busy_fall", 32'(cyc_n), 32'(log_cyc[3] + 1));
    end

    // Flush of a partial burst
    clear_log();
    push_one(16'd5); push_one(16'd6);
    commit();
    cyc();
    chk("partial_no_trigger", 32'(busy), 32'd0);
    flush = 1'b1;
    model_flush();
    cyc();
    flush = 1'b0;
    drain(1'b0);
    chk_log("flush_burst", 2, 16'd6, 16'd5, 16'd0, 16'd0);
    chk("flush_rdreq_cnt", 32'(rd_cnt), 32'd2);

    // Backpressure: out_ready low for 5 cycles after the trigger
    clear_log();
    out_ready = 1'b0;
    push_one(16'd20); push_one(16'd21); push_one(16'd22); push_one(16'd23);
    commit();
    repeat (6) cyc();
    chk("bp_rd_le2", 32'(rd_cnt <= 2), 32'd1);
    chk("bp_valid_stalled", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain(1'b0);
    chk_log("bp_burst", 4, 16'd23, 16'd22, 16'd21, 16'd20);

`ifdef LIFO_BURST_READER_STATS_EN
    chk("stats_three_bursts", 32'(burst_cnt), 32'd3);
`endif

    // Flush with empty LIFO: no action
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (3) begin
      cyc();
      chk("empty_flush_busy",  32'(busy), 32'd0);
      chk("empty_flush_rdreq", 32'(lifo_rdreq), 32'd0);
    end
`ifdef LIFO_BURST_READER_STATS_EN
    chk("stats_after_empty_flush", 32'(burst_cnt), 32'd3);
`endif

    // Flush during a busy burst is ignored, not queued
    clear_log();
    push_one(16'd50); push_one(16'd51); push_one(16'd52);
    push_one(16'd53); push_one(16'd54); push_one(16'd55);
    commit();
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drain(1'b0);
    chk_log("busy_flush_burst", 4, 16'd55, 16'd54, 16'd53, 16'd52);
    repeat (4) cyc();
    chk("busy_flush_left", 32'(sp), 32'd2);
    chk("busy_flush_idle", 32'(busy), 32'd0);
    flush = 1'b1;
    model_flush();
    cyc();
    flush = 1'b0;
    drain(1'b0);

    // Reset after the 2nd word of a burst
    clear_log();
    out_ready = 1'b1;
    push_one(16'd30); push_one(16'd31); push_one(16'd32); push_one(16'd33);
    commit();
    for (int i = 0; i < 50 && log_d.size() < 2; i++) cyc();
    if (log_d.size() != 2) fail("mid_reset_setup");
    arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_last",  32'(out_last),  32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd0);
    chk("mid_rst_rdreq", 32'(lifo_rdreq), 32'd0);
    exp_d.delete();
    exp_l.delete();
    rstk.delete();
    sp = 0;
    lifo_q = 16'hDEAD;
    upd_lifo();
    issued = 0;
    delivered = 0;
    prev_stall = 1'b0;
    lasts_since_rst = 0;
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (5) begin
      cyc();
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    clear_log();
    push_one(16'd40); push_one(16'd41); push_one(16'd42); push_one(16'd43);
    commit();
    drain(1'b0);
    chk_log("post_rst_burst", 4, 16'd43, 16'd42, 16'd41, 16'd40);

    // Random backpressure over at least 100 bursts
    start_b = model_bursts;
    start_l = dut_lasts;
    for (int it = 0; it < 400 && (model_bursts - start_b) < 100; it++) begin
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) push_one(16'($urandom));
      commit();
      drain(1'b1);
      if (rstk.size() > 0 && $urandom_range(0, 1) == 1) begin
        flush = 1'b1;
        model_flush();
        cyc();
        flush = 1'b0;
        drain(1'b1);
      end
    end
    chk("rand_bursts_ge100", 32'((model_bursts - start_b) >= 100), 32'd1);
    chk("rand_one_last_per_burst", 32'(dut_lasts - start_l), 32'(model_bursts - start_b));
    chk("rand_all_delivered", 32'(exp_d.size()), 32'd0);

`ifdef LIFO_BURST_READER_STATS_EN
    chk("stats_final", 32'(burst_cnt), 32'(lasts_since_rst & 16'hFFFF));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
